// File: rtl/drive_nav_ctrl.sv
// drive_nav_ctrl: semi-auto / auto navigation controller for the car.
//
// Operation: OFF -> WAIT at a fork -> TURN (timed) -> SETTLE (blind straight)
// -> CRUISE (straight, watching the detectors) -> back to WAIT at the next fork.
// In semi-auto, WAIT pops operator commands from a FIFO. In auto, WAIT picks
// the first open side using a right-hand rule (right, front, left, U-turn).
//
// Ports:
//   sys_clk, rst_n        clock, asynchronous active-low reset
//   power_on, power_off   one-cycle pulses; power_off has priority
//   auto_mode             0 = queue-driven, 1 = detector-driven (read in WAIT)
//   cmd_valid, cmd_dir    operator command offer (00 S, 01 L, 10 R, 11 U)
//   cmd_ready             queue accepts a command (powered and not full)
//   det                   {back,right,left,front}, 1 = wall present
//   go_straight/back/left/right  registered motion commands
//   state_o               current state encoding
//   q_count               queue occupancy
//   fork_o                one-cycle pulse when CRUISE reaches a fork
//   uart_byte             {2'b10,2'b00,go_right,go_left,go_back,go_straight}
module drive_nav_ctrl #(
  parameter int unsigned TURN_CYCLES = 90_000_000,
  parameter int unsigned MOVE_CYCLES = 30_000_000,
  parameter int unsigned QDEPTH      = 4,
  parameter int unsigned CNT_W       = 28
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic                      power_on,
  input  logic                      power_off,
  input  logic                      auto_mode,
  input  logic                      cmd_valid,
  input  logic [1:0]                cmd_dir,
  output logic                      cmd_ready,
  input  logic [3:0]                det,
  output logic                      go_straight,
  output logic                      go_back,
  output logic                      go_left,
  output logic                      go_right,
  output logic [2:0]                state_o,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic                      fork_o,
  output logic [7:0]                uart_byte
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned QC_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] UTURN_LAST = CNT_W'(2 * TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] MOVE_LAST  = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [QC_W-1:0]  FULL_CNT   = QC_W'(QDEPTH);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_WAIT   = 3'd1,
    S_TURN   = 3'd2,
    S_SETTLE = 3'd3,
    S_CRUISE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    DIR_STRAIGHT = 2'b00,
    DIR_LEFT     = 2'b01,
    DIR_RIGHT    = 2'b10,
    DIR_UTURN    = 2'b11
  } dir_e;

  state_e            state_q, state_d;
  dir_e              dir_q, dir_d;
  dir_e              auto_dir, take_dir;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QC_W-1:0]   count_q, count_d;
  logic [1:0]        mem_q [QDEPTH];
  logic              fork_q, fork_d;
  logic              go_straight_q, go_straight_d;
  logic              go_left_q, go_left_d;
  logic              go_right_q, go_right_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              push, pop, take;
  logic              unused_det;

  // The back detector plays no part in navigation here.
  assign unused_det = det[3];

  assign push = cmd_valid && cmd_ready_q;

  // Right-hand rule: right, then front, then left, else U-turn.
  always_comb begin
    if (!det[2])      auto_dir = DIR_RIGHT;
    else if (!det[0]) auto_dir = DIR_STRAIGHT;
    else if (!det[1]) auto_dir = DIR_LEFT;
    else              auto_dir = DIR_UTURN;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d  = state_q;
    dir_d    = dir_q;
    timer_d  = timer_q;
    fork_d   = 1'b0;
    pop      = 1'b0;
    take     = 1'b0;
    take_dir = DIR_STRAIGHT;

    unique case (state_q)
      S_OFF: if (power_on) state_d = S_WAIT;
      S_WAIT: begin
        if (auto_mode) begin
          take     = 1'b1;
          take_dir = auto_dir;
        end else if (count_q != '0) begin
          // The queue is read from registered state, so a command pushed
          // this cycle cannot be popped before the next one.
          take     = 1'b1;
          pop      = 1'b1;
          take_dir = dir_e'(mem_q[rd_ptr_q]);
        end
        if (take) begin
          dir_d   = take_dir;
          timer_d = '0;
          state_d = (take_dir == DIR_STRAIGHT) ? S_SETTLE : S_TURN;
        end
      end
      S_TURN: begin
        if (timer_q == ((dir_q == DIR_UTURN) ? UTURN_LAST : TURN_LAST)) begin
          state_d = S_SETTLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (timer_q == MOVE_LAST) begin
          state_d = S_CRUISE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      S_CRUISE: begin
        // Open left, open right or blocked front all mean a fork.
        if (!det[1] || !det[2] || det[0]) begin
          state_d = S_WAIT;
          fork_d  = 1'b1;
        end
      end
      default: state_d = S_OFF;
    endcase

    if (power_off) begin
      state_d = S_OFF;
      timer_d = '0;
      fork_d  = 1'b0;
      pop     = 1'b0;
    end
  end

  always_comb begin
    if (power_off) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are log2(QDEPTH) wide, so they wrap on their own.
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + QC_W'(push) - QC_W'(pop);
    end
  end

  // Outputs are computed from next state so they line up with state_o.
  assign go_straight_d = (state_d == S_SETTLE) || (state_d == S_CRUISE);
  assign go_left_d     = (state_d == S_TURN) && (dir_d == DIR_LEFT);
  assign go_right_d    = (state_d == S_TURN) &&
                         ((dir_d == DIR_RIGHT) || (dir_d == DIR_UTURN));
  assign cmd_ready_d   = (state_d != S_OFF) && (count_d != FULL_CNT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_OFF;
      dir_q         <= DIR_STRAIGHT;
      timer_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      fork_q        <= 1'b0;
      go_straight_q <= 1'b0;
      go_left_q     <= 1'b0;
      go_right_q    <= 1'b0;
      cmd_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      timer_q       <= timer_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      fork_q        <= fork_d;
      go_straight_q <= go_straight_d;
      go_left_q     <= go_left_d;
      go_right_q    <= go_right_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  // NOTE: queue storage has no reset; entries are only read when count_q
  // says they were written, so clearing them would be wasted logic.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_dir;
  end

  assign cmd_ready   = cmd_ready_q;
  assign go_straight = go_straight_q;
  assign go_left     = go_left_q;
  assign go_right    = go_right_q;
  assign go_back     = 1'b0;
  assign state_o     = state_q;
  assign q_count     = count_q;
  assign fork_o      = fork_q;
  assign uart_byte   = {2'b10, 2'b00, go_right_q, go_left_q, 1'b0, go_straight_q};

endmodule

// File: tb/tb_drive_nav_ctrl.sv
// Testbench for drive_nav_ctrl with short timers (turn 8, settle 4, queue 4).
module tb_drive_nav_ctrl;

  localparam int TC = 8;
  localparam int MC = 4;
  localparam int QD = 4;
  localparam int CW = 8;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       power_on, power_off, auto_mode, cmd_valid;
  logic [1:0] cmd_dir;
  logic       cmd_ready;
  logic [3:0] det;
  logic       go_straight, go_back, go_left, go_right;
  logic [2:0] state_o;
  logic [2:0] q_count;
  logic       fork_o;
  logic [7:0] uart_byte;

  drive_nav_ctrl #(
    .TURN_CYCLES(TC), .MOVE_CYCLES(MC), .QDEPTH(QD), .CNT_W(CW)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .power_on(power_on), .power_off(power_off),
    .auto_mode(auto_mode), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
    .cmd_ready(cmd_ready), .det(det), .go_straight(go_straight), .go_back(go_back),
    .go_left(go_left), .go_right(go_right), .state_o(state_o), .q_count(q_count),
    .fork_o(fork_o), .uart_byte(uart_byte)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int st, input int q, input bit rdy,
                            input bit gs, input bit gl, input bit gr, input bit fk);
    logic [7:0] u;
    u = {4'b1000, gr, gl, 1'b0, gs};
    check({tag, ".state"}, 32'(state_o), st);
    check({tag, ".q_count"}, 32'(q_count), q);
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(rdy));
    check({tag, ".go_straight"}, 32'(go_straight), 32'(gs));
    check({tag, ".go_left"}, 32'(go_left), 32'(gl));
    check({tag, ".go_right"}, 32'(go_right), 32'(gr));
    check({tag, ".go_back"}, 32'(go_back), 0);
    check({tag, ".fork"}, 32'(fork_o), 32'(fk));
    check({tag, ".uart"}, 32'(uart_byte), 32'(u));
  endtask

  // From WAIT: one decision cycle, the timed turn, settle, one cruise cycle,
  // then a fork (det 1101) back to WAIT. det 1110 is a plain corridor.
  task automatic do_manoeuvre(input string tag, input int d, input bit am,
                              input logic [3:0] det_dec, input int q_exp);
    int n_turn;
    n_turn = (d == 0) ? 0 : ((d == 3) ? 2 * TC : TC);
    auto_mode = am; det = det_dec; cmd_valid = 1'b0;
    for (int i = 0; i < n_turn; i++) begin
      tick(); det = 4'b1110;
      check_outs({tag, ".turn"}, 2, q_exp, 1, 0, d == 1, d != 1, 0);
    end
    for (int i = 0; i < MC; i++) begin
      tick(); det = 4'b1110;
      check_outs({tag, ".settle"}, 3, q_exp, 1, 1, 0, 0, 0);
    end
    tick();
    check_outs({tag, ".cruise"}, 4, q_exp, 1, 1, 0, 0, 0);
    det = 4'b1101;
    tick();
    check_outs({tag, ".fork"}, 1, q_exp, 1, 0, 0, 0, 1);
    det = 4'b1110;
  endtask

  // Reference model: remaining-cycle countdown and a queue of directions.
  int m_state, m_rem, m_dir;
  int mq[$];
  bit m_fork;

  task automatic model_step();
    bit rdy, push, go;
    int d;
    rdy  = (m_state != 0) && (mq.size() < QD);
    push = cmd_valid && rdy;
    m_fork = 1'b0;
    if (power_off) begin
      m_state = 0; m_rem = 0; mq.delete();
    end else begin
      go = 1'b0; d = 0;
      case (m_state)
        0: if (power_on) m_state = 1;
        1: begin
          if (auto_mode) begin
            go = 1'b1;
            if (!det[2]) d = 2; else if (!det[0]) d = 0; else if (!det[1]) d = 1; else d = 3;
          end else if (mq.size() > 0) begin
            go = 1'b1;
            d = mq.pop_front();
          end
          if (go) begin
            m_dir = d;
            if (d == 0) begin m_state = 3; m_rem = MC; end
            else begin m_state = 2; m_rem = (d == 3) ? 2 * TC : TC; end
          end
        end
        2: begin m_rem--; if (m_rem == 0) begin m_state = 3; m_rem = MC; end end
        3: begin m_rem--; if (m_rem == 0) m_state = 4; end
        4: if (!det[1] || !det[2] || det[0]) begin m_state = 1; m_fork = 1'b1; end
        default: ;
      endcase
      if (push) mq.push_back(int'(cmd_dir));
    end
  endtask

  typedef struct {
    bit p_on, p_off, am, cv;
    logic [1:0] cd;
    logic [3:0] dt;
    int st, q;
    bit rdy, gs, gl, gr, fk;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0; power_on = 0; power_off = 0; auto_mode = 0;
    cmd_valid = 0; cmd_dir = 2'b00; det = 4'b1110;

    //            on off am cv dir    det      st q rdy gs gl gr fk
    vecs.push_back('{1, 1, 0, 0, 2'b00, 4'b1110, 0, 0, 0, 0, 0, 0, 0}); // on+off -> OFF
    vecs.push_back('{0, 0, 0, 1, 2'b01, 4'b1110, 0, 0, 0, 0, 0, 0, 0}); // push while OFF
    vecs.push_back('{1, 0, 0, 0, 2'b00, 4'b1110, 1, 0, 1, 0, 0, 0, 0}); // power on
    vecs.push_back('{0, 0, 1, 0, 2'b00, 4'b0100, 3, 0, 1, 1, 0, 0, 0}); // auto, front open
    vecs.push_back('{0, 0, 0, 1, 2'b10, 4'b1110, 3, 1, 1, 1, 0, 0, 0}); // push R
    vecs.push_back('{0, 0, 0, 1, 2'b01, 4'b1110, 3, 2, 1, 1, 0, 0, 0}); // push L
    vecs.push_back('{0, 0, 0, 1, 2'b11, 4'b1110, 3, 3, 1, 1, 0, 0, 0}); // push U
    vecs.push_back('{0, 0, 0, 1, 2'b00, 4'b1110, 4, 4, 0, 1, 0, 0, 0}); // push S, full
    vecs.push_back('{0, 0, 0, 1, 2'b01, 4'b1110, 4, 4, 0, 1, 0, 0, 0}); // 5th dropped
    vecs.push_back('{0, 0, 0, 0, 2'b00, 4'b1101, 1, 4, 0, 0, 0, 0, 1}); // fork

    #12;
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge sys_clk); rst_n = 1'b1;

    foreach (vecs[i]) begin
      power_on = vecs[i].p_on; power_off = vecs[i].p_off; auto_mode = vecs[i].am;
      cmd_valid = vecs[i].cv; cmd_dir = vecs[i].cd; det = vecs[i].dt;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].q, vecs[i].rdy,
                 vecs[i].gs, vecs[i].gl, vecs[i].gr, vecs[i].fk);
    end
    power_on = 0; power_off = 0; cmd_valid = 0;

    // FIFO order: R, L, U, S.
    do_manoeuvre("fifo_R", 2, 0, 4'b1110, 3);
    do_manoeuvre("fifo_L", 1, 0, 4'b1110, 2);
    do_manoeuvre("fifo_U", 3, 0, 4'b1110, 1);
    do_manoeuvre("fifo_S", 0, 0, 4'b1110, 0);

    // No bypass into an empty queue, then push and pop in one cycle.
    auto_mode = 0; cmd_valid = 1; cmd_dir = 2'b00;
    tick();
    check_outs("nobypass", 1, 1, 1, 0, 0, 0, 0);
    cmd_dir = 2'b01;
    tick();
    check_outs("pushpop", 3, 1, 1, 1, 0, 0, 0);
    cmd_valid = 0;
    for (int i = 1; i < MC; i++) begin
      tick();
      check_outs("pushpop.settle", 3, 1, 1, 1, 0, 0, 0);
    end
    tick();
    check_outs("pushpop.cruise", 4, 1, 1, 1, 0, 0, 0);
    det = 4'b1101;
    tick();
    check_outs("pushpop.fork", 1, 1, 1, 0, 0, 0, 1);
    det = 4'b1110;
    do_manoeuvre("pushpop.L", 1, 0, 4'b1110, 0);

    // Auto right-hand rule.
    do_manoeuvre("auto_0101", 1, 1, 4'b0101, 0);
    do_manoeuvre("auto_0111", 3, 1, 4'b0111, 0);
    do_manoeuvre("auto_1111", 3, 1, 4'b1111, 0);
    do_manoeuvre("auto_0100", 0, 1, 4'b0100, 0);
    do_manoeuvre("auto_1011", 2, 1, 4'b1011, 0);

    // power_off mid-turn with three commands queued.
    auto_mode = 1; det = 4'b1011;
    tick();
    check_outs("poff.turn", 2, 0, 1, 0, 0, 1, 0);
    auto_mode = 0; cmd_valid = 1; cmd_dir = 2'b01;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_outs("poff.push", 2, i, 1, 0, 0, 1, 0);
    end
    cmd_valid = 0; power_off = 1;
    tick();
    check_outs("poff", 0, 0, 0, 0, 0, 0, 0);
    power_off = 0; cmd_valid = 1;
    tick();
    check_outs("poff.hold", 0, 0, 0, 0, 0, 0, 0);
    cmd_valid = 0;

    // Reset asserted mid-turn.
    power_on = 1;
    tick();
    power_on = 0; auto_mode = 1; det = 4'b1011;
    tick();
    check_outs("rst.turn", 2, 0, 1, 0, 0, 1, 0);
    tick();
    #2 rst_n = 1'b0;
    #1 check_outs("rst.mid", 0, 0, 0, 0, 0, 0, 0);
    @(negedge sys_clk); rst_n = 1'b1;
    tick();
    check_outs("rst.after", 0, 0, 0, 0, 0, 0, 0);

    // Randomized run against the model.
    m_state = 0; m_rem = 0; m_dir = 0; m_fork = 0; mq.delete();
    auto_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      power_on  = ($urandom % 12) == 0;
      power_off = ($urandom % 150) == 0;
      if (($urandom % 40) == 0) auto_mode = ~auto_mode;
      cmd_valid = ($urandom % 3) == 0;
      cmd_dir   = 2'($urandom);
      det       = 4'($urandom);
      model_step();
      tick();
      check_outs("rand", m_state, mq.size(), (m_state != 0) && (mq.size() < QD),
                 (m_state == 3) || (m_state == 4),
                 (m_state == 2) && (m_dir == 1),
                 (m_state == 2) && (m_dir >= 2), m_fork);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
